// File: rtl/count_enable_gen.sv
// Push-button to count-enable pulse generator: synchronizer, debounce FSM,
// single-step press pulse and auto-repeat prescaler.
module count_enable_gen #(
    parameter int DB_CYCLES = 16,
    parameter int PRESCALE  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic mode,
    output logic en,
    output logic btn_level
);

    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REL_WAIT
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          meta;
    logic          sync;
    logic [DW-1:0] db_cnt;
    logic [DW-1:0] db_nx;
    logic [PW-1:0] psc;
    logic [PW-1:0] psc_nx;
    logic          press;
    logic          enter_held;
    logic          wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta      <= 1'b0;
            sync      <= 1'b0;
            state     <= IDLE;
            db_cnt    <= '0;
            psc       <= '0;
            en        <= 1'b0;
            btn_level <= 1'b0;
        end else begin
            meta      <= btn_in;
            sync      <= meta;
            state     <= state_nx;
            db_cnt    <= db_nx;
            psc       <= psc_nx;
            en        <= press | wrap;
            btn_level <= (state_nx == HELD) || (state_nx == REL_WAIT);
        end
    end

    always_comb begin
        state_nx   = state;
        db_nx      = db_cnt;
        press      = 1'b0;
        enter_held = 1'b0;
        unique case (state)
            IDLE: begin
                if (sync) begin
                    state_nx = PRESS_WAIT;
                    db_nx    = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync) begin
                    state_nx = IDLE;
                    db_nx    = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_nx   = HELD;
                    db_nx      = '0;
                    press      = 1'b1;
                    enter_held = 1'b1;
                end else begin
                    db_nx = db_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!sync) begin
                    state_nx = REL_WAIT;
                    db_nx    = '0;
                end
            end
            REL_WAIT: begin
                if (sync) begin
                    state_nx   = HELD;
                    db_nx      = '0;
                    enter_held = 1'b1;
                end else if (db_cnt == DB_LAST) begin
                    state_nx = IDLE;
                    db_nx    = '0;
                end else begin
                    db_nx = db_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                db_nx    = '0;
            end
        endcase
    end

    // btn_level mirrors HELD/REL_WAIT, so it gates auto-repeat through release
    always_comb begin
        psc_nx = psc;
        wrap   = 1'b0;
        if (enter_held || !mode || !btn_level) begin
            psc_nx = '0;
        end else if (psc == PS_LAST) begin
            psc_nx = '0;
            wrap   = 1'b1;
        end else begin
            psc_nx = psc + 1'b1;
        end
    end

endmodule

// File: tb/tb_count_enable_gen.sv
// Bench for count_enable_gen: directed scenarios plus random stimulus
// checked cycle by cycle against a run-length debounce reference model.
module tb_count_enable_gen;

    localparam int DB = 4;
    localparam int PS = 8;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic mode;
    logic en;
    logic btn_level;

    int tests = 0;
    int fails = 0;

    int          edge_no;
    logic [63:0] hist;
    logic [63:0] exp_hist;
    int          ds_count;
    logic        prev_en;

    // reference model state
    logic ms1, ms2, mlevel, men;
    int   mrun, mpsc;

    always #5 clk = ~clk;

    count_enable_gen #(.DB_CYCLES(DB), .PRESCALE(PS)) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .mode(mode),
        .en(en),
        .btn_level(btn_level)
    );

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Level flips once DB+1 consecutive synchronized samples disagree with it
    task automatic model_update(input logic b, input logic m, input logic r);
        logic samp, old_level, pulse, auto_p, enter;
        if (r) begin
            ms1 = 0; ms2 = 0; mlevel = 0; men = 0; mrun = 0; mpsc = 0;
        end else begin
            samp      = ms2;
            old_level = mlevel;
            pulse     = 0;
            auto_p    = 0;
            enter     = 0;
            if (samp != old_level) begin
                mrun++;
                if (mrun == DB + 1) begin
                    mlevel = samp;
                    mrun   = 0;
                    pulse  = samp;
                    enter  = samp;
                end
            end else begin
                enter = old_level && (mrun > 0);
                mrun  = 0;
            end
            if (enter || !m || !old_level) mpsc = 0;
            else if (mpsc == PS - 1) begin
                mpsc   = 0;
                auto_p = 1;
            end else mpsc++;
            men = pulse | auto_p;
            ms2 = ms1;
            ms1 = b;
        end
    endtask

    task automatic step(input logic b, input logic m, input logic r);
        btn_in = b;
        mode   = m;
        rst    = r;
        @(posedge clk);
        model_update(b, m, r);
        edge_no++;
        @(negedge clk);
        check_bit("en_vs_model", en, men);
        check_bit("level_vs_model", btn_level, mlevel);
        check_bit("en_back_to_back", en & prev_en, 1'b0);
        prev_en = en;
        if (en) begin
            ds_count++;
            if (edge_no < 64) hist[edge_no] = 1'b1;
        end
    endtask

    task automatic start();
        edge_no  = 0;
        hist     = '0;
        exp_hist = '0;
    endtask

    task automatic settle_low(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int len;
        logic b;
        logic m;
        prev_en  = 1'b0;
        ds_count = 0;
        edge_no  = 0;
        hist     = '0;
        exp_hist = '0;
        ms1 = 0; ms2 = 0; mlevel = 0; men = 0; mrun = 0; mpsc = 0;

        // reset state
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check_bit("reset_en", en, 1'b0);
        check_bit("reset_level", btn_level, 1'b0);
        settle_low(3);

        // single press, mode 0
        start();
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i == 6) check_bit("press_level_e6", btn_level, 1'b0);
            if (i == 7) check_bit("press_level_e7", btn_level, 1'b1);
        end
        exp_hist[7] = 1'b1;
        check_vec("single_press_edges", hist, exp_hist);
        settle_low(12);

        // short bounces never qualify
        start();
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
        end
        check_vec("bounce_no_pulse", hist, exp_hist);
        check_bit("bounce_level", btn_level, 1'b0);

        // auto-repeat
        start();
        for (int i = 1; i <= 40; i++) step(1'b1, 1'b1, 1'b0);
        exp_hist[7]  = 1'b1;
        exp_hist[15] = 1'b1;
        exp_hist[23] = 1'b1;
        exp_hist[31] = 1'b1;
        exp_hist[39] = 1'b1;
        check_vec("auto_edges", hist, exp_hist);
        settle_low(12);

        // mode dropped mid-run, then re-press
        start();
        for (int i = 1; i <= 40; i++) step(1'b1, (i < 20), 1'b0);
        exp_hist[7]  = 1'b1;
        exp_hist[15] = 1'b1;
        check_vec("mode_drop_edges", hist, exp_hist);
        settle_low(12);
        start();
        for (int i = 1; i <= 20; i++) step(1'b1, 1'b0, 1'b0);
        exp_hist[7] = 1'b1;
        check_vec("repress_edges", hist, exp_hist);
        settle_low(12);

        // reset during PRESS_WAIT
        start();
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0, (i == 6));
            if (i == 6) begin
                check_bit("rst_mid_en", en, 1'b0);
                check_bit("rst_mid_level", btn_level, 1'b0);
            end
        end
        exp_hist[13] = 1'b1;
        check_vec("rst_mid_edges", hist, exp_hist);
        settle_low(12);

        // downstream counter, clean presses
        ds_count = 0;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);
            settle_low(12);
        end
        check_int("ds_clean", ds_count, 5);

        // downstream counter, bouncy edges
        ds_count = 0;
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 4; j++) begin
                len = $urandom_range(1, 3);
                for (int i = 0; i < len; i++) step(1'b1, 1'b0, 1'b0);
                len = $urandom_range(1, 3);
                for (int i = 0; i < len; i++) step(1'b0, 1'b0, 1'b0);
            end
            for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);
            for (int j = 0; j < 4; j++) begin
                len = $urandom_range(1, 3);
                for (int i = 0; i < len; i++) step(1'b0, 1'b0, 1'b0);
                len = $urandom_range(1, 3);
                for (int i = 0; i < len; i++) step(1'b1, 1'b0, 1'b0);
            end
            settle_low(12);
        end
        check_int("ds_bouncy", ds_count, 5);

        // random segments against the model
        m = 1'b0;
        for (int s = 0; s < 400; s++) begin
            b   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 14);
            if ($urandom_range(0, 5) == 0) m = ~m;
            for (int i = 0; i < len; i++)
                step(b, m, ($urandom_range(0, 199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/count_enable_gen.md
COUNT_ENABLE_GEN -- requirements
Module: count_enable_gen

Interface
REQ-001 Parameter DB_CYCLES, default 16: consecutive synchronized samples required to accept a level change; legal range >= 2.
REQ-002 Parameter PRESCALE, default 8: auto-repeat period in clk cycles; legal range >= 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-005 btn_in  input  1  raw, asynchronous, bouncing push-button level; 1 = pressed.
REQ-006 mode  input  1  0 = single-step (one pulse per press); 1 = auto-repeat while held.
REQ-007 en  output  1  registered one-cycle count-enable pulse, driving the downstream up-counter enable.
REQ-008 btn_level  output  1  registered debounced button level; 1 in HELD or REL_WAIT.

Function
REQ-009 The block SHALL pass btn_in through a 2-flop synchronizer; only the second flop (sync) feeds the FSM.
REQ-010 The FSM SHALL have exactly four states: IDLE, PRESS_WAIT, HELD, REL_WAIT.
REQ-011 IDLE: sync=1 -> PRESS_WAIT with the debounce counter cleared to 0; otherwise stay.
REQ-012 PRESS_WAIT: sync=0 -> IDLE, counter cleared; sync=1 and counter=DB_CYCLES-1 -> HELD; otherwise counter +1.
REQ-013 HELD: sync=0 -> REL_WAIT with counter cleared; otherwise stay.
REQ-014 REL_WAIT: sync=1 -> HELD, counter cleared; sync=0 and counter=DB_CYCLES-1 -> IDLE; otherwise counter +1.
REQ-015 The debounce counter SHALL be clog2(DB_CYCLES) bits wide and SHALL never exceed DB_CYCLES-1.
REQ-016 On the PRESS_WAIT->HELD transition, en SHALL be 1 for exactly one cycle, in both modes.
REQ-017 Press latency: counting the first edge that samples btn_in=1 as edge 1, en SHALL rise at edge DB_CYCLES+3 and fall at edge DB_CYCLES+4 if btn_in stays high.
REQ-018 Prescaler: a clog2(PRESCALE)-bit counter; cleared to 0 on entry to HELD, and whenever mode=0 or btn_level=0.
REQ-019 With mode=1 in HELD or REL_WAIT, the prescaler SHALL increment each cycle; at PRESCALE-1, en SHALL pulse for one cycle and the prescaler SHALL wrap to 0.
REQ-020 First auto pulse: PRESCALE edges after the press pulse; successive pulses exactly PRESCALE cycles apart.
REQ-021 mode 1->0 while held: prescaler cleared, no further pulses until the next press; mode 0->1 while held: first pulse PRESCALE edges later.
REQ-022 en SHALL never be high on two consecutive cycles; a press pulse and a prescaler wrap SHALL never coincide.
REQ-023 Bounce shorter than DB_CYCLES samples in either direction SHALL produce no en pulse and no btn_level change.
REQ-024 The release debounce (REL_WAIT) SHALL produce no en pulse; auto-repeat continues through REL_WAIT.

Reset
REQ-025 rst=1 SHALL set on the next edge: synchronizer flops 0, state IDLE, both counters 0, en=0, btn_level=0.
REQ-026 rst SHALL override all other inputs, including a same-cycle PRESS_WAIT->HELD transition; no en pulse in that cycle.
REQ-027 A button held through reset release SHALL require a full DB_CYCLES qualification before the first en pulse.

Verification
REQ-028 DB_CYCLES=4, mode=0, btn_in 0->1 held 20 cycles -> single en pulse at edge 7, btn_level=1 from edge 7; no further pulses.
REQ-029 DB_CYCLES=4, btn_in pulses high 3 cycles, then low, repeated 5 times -> en never 1, btn_level stays 0.
REQ-030 DB_CYCLES=4, PRESCALE=8, mode=1, held 40 cycles -> en at edges 7, 15, 23, 31, 39 only.
REQ-031 Auto-run held, mode dropped to 0 at edge 20 -> no en after edge 15; release then re-press -> exactly one new press pulse.
REQ-032 rst asserted at edge 6 while in PRESS_WAIT, btn_in held high -> no pulse at edge 7; outputs 0; press pulse at edge DB_CYCLES+3 counting from the first post-reset sample.
REQ-033 Downstream counter driven by en, 5 clean presses in mode=0 -> counter value 5; with 2 ms bounce on each edge -> still 5.
